// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one single-port RAM between two requesters.
// Ports: req/we/addr/wdata in and gnt/rvalid out per requester; shared rdata; registered ram_* outputs.
// Latency: the RAM command is issued at the grant edge, and rvalid arrives 2 cycles after gnt.
// Backpressure: a requester holds its command until it sees gnt; it is masked in its grant cycle.
// Optional macro RAM_ARB_STALL_COUNT_EN adds stat_clr, stall0 and stall1 (saturating stall counters).
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  busy
`ifdef RAM_ARB_STALL_COUNT_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           stall0,
  output logic [15:0]           stall1
`endif
);

  logic elig0, elig1;
  logic win0, win1;
  logic last_winner;     // 1 = requester 1 won last, so requester 0 takes the next tie
  logic rd_s1_vld, rd_s1_id;
  logic rd_s2_vld, rd_s2_id;

  // A requester granted this cycle is masked, so it cannot win twice in a row.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    win0  = 1'b0;
    win1  = 1'b0;
    if (elig0 && elig1) begin
      win0 = last_winner;
      win1 = ~last_winner;
    end else begin
      win0 = elig0;
      win1 = elig1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata       <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_data    <= '0;
      last_winner <= 1'b1;
      rd_s1_vld   <= 1'b0;
      rd_s1_id    <= 1'b0;
      rd_s2_vld   <= 1'b0;
      rd_s2_id    <= 1'b0;
    end else begin
      gnt0 <= win0;
      gnt1 <= win1;
      if (win0 || win1) begin
        ram_addr    <= win1 ? addr1  : addr0;
        ram_data    <= win1 ? wdata1 : wdata0;
        ram_we      <= win1 ? we1    : we0;
        last_winner <= win1;
      end else begin
        ram_we <= 1'b0;
      end
      // Read tag pipeline: stage 1 lines up with the RAM command, stage 2 with ram_out.
      rd_s1_vld <= (win0 & ~we0) | (win1 & ~we1);
      rd_s1_id  <= win1;
      rd_s2_vld <= rd_s1_vld;
      rd_s2_id  <= rd_s1_id;
      rvalid0   <= rd_s2_vld & ~rd_s2_id;
      rvalid1   <= rd_s2_vld & rd_s2_id;
      if (rd_s2_vld) begin
        rdata <= ram_out;
      end
    end
  end

  assign busy = ram_we | rd_s1_vld | rd_s2_vld;

`ifdef RAM_ARB_STALL_COUNT_EN
  // A stall is any cycle with the request high that is not followed by a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall0 <= '0;
      stall1 <= '0;
    end else if (stat_clr) begin
      stall0 <= '0;
      stall1 <= '0;
    end else begin
      if (req0 && !win0 && stall0 != 16'hFFFF) begin
        stall0 <= stall0 + 16'd1;
      end
      if (req1 && !win1 && stall1 != 16'hFFFF) begin
        stall1 <= stall1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a write-first single-port RAM model.
// Inputs change and outputs are sampled #1 after each rising edge.
module tb_ram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out;
  logic          busy;
`ifdef RAM_ARB_STALL_COUNT_EN
  logic          stat_clr;
  logic [15:0]   stall0, stall1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .ram_out(ram_out), .busy(busy)
`ifdef RAM_ARB_STALL_COUNT_EN
    , .stat_clr(stat_clr), .stall0(stall0), .stall1(stall1)
`endif
  );

  // Write-first single-port RAM, registered output.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial ram_out = '0;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      ram_out       <= ram_data;
    end else begin
      ram_out <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  initial begin
    idle_inputs();
`ifdef RAM_ARB_STALL_COUNT_EN
    stat_clr = 0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset = 1;
    step();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid", {rvalid0, rvalid1}, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    step();

    // Write 0xA5 to address 5 from requester 0.
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 8'hA5;
    step();
    check("wr_gnt0", gnt0, 1);
    check("wr_gnt1", gnt1, 0);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 5);
    check("wr_ram_data", ram_data, 8'hA5);
    check("wr_busy", busy, 1);
    check("wr_no_rvalid", {rvalid0, rvalid1}, 0);

    // Requester 1 reads it back, presented in the cycle gnt0 is seen.
    idle_inputs();
    req1 = 1; we1 = 0; addr1 = 5;
    step();
    check("rd_gnt1", gnt1, 1);
    check("rd_gnt0", gnt0, 0);
    check("rd_ram_we", ram_we, 0);
    idle_inputs();
    step();
    check("rd_early_rvalid1", rvalid1, 0);
    step();
    check("rd_rvalid1", rvalid1, 1);
    check("rd_rvalid0", rvalid0, 0);
    check("rd_rdata", rdata, 8'hA5);
    step();
    check("rd_rvalid_drop", {rvalid0, rvalid1}, 0);
    check("rd_rdata_hold", rdata, 8'hA5);
    check("rd_idle_busy", busy, 0);

    // Preload addresses 1 and 2.
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 8'h11;
    step();
    idle_inputs();
    req1 = 1; we1 = 1; addr1 = 2; wdata1 = 8'h22;
    step();
    idle_inputs();
    step();

    // Both request reads for 6 cycles: grants alternate starting with requester 0.
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("alt_gnt0_%0d", k), gnt0, (k < 6) && (k % 2 == 0));
      check($sformatf("alt_gnt1_%0d", k), gnt1, (k < 6) && (k % 2 == 1));
      if (k >= 2) begin
        check($sformatf("alt_rv0_%0d", k), rvalid0, (k % 2 == 0));
        check($sformatf("alt_rv1_%0d", k), rvalid1, (k % 2 == 1));
        check($sformatf("alt_rdata_%0d", k), rdata, (k % 2 == 0) ? 8'h11 : 8'h22);
      end
      if (k == 5) idle_inputs();
    end
    step();

    // Single requester held continuously: never two consecutive grants.
    req0 = 1; we0 = 0; addr0 = 2;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("solo_gnt0_%0d", k), gnt0, (k % 2 == 0));
    end
    idle_inputs();
    step();
    step();
    step();

    // Read granted, then reset in the next cycle.
    req0 = 1; we0 = 0; addr0 = 1;
    step();
    check("rr_gnt0", gnt0, 1);
    idle_inputs();
    reset = 1;
    #1;
    check("rr_gnt0_clr", gnt0, 0);
    check("rr_busy_clr", busy, 0);
    check("rr_ram_addr_clr", ram_addr, 0);
    check("rr_ram_we_clr", ram_we, 0);
    step();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr_no_rvalid_%0d", k), {rvalid0, rvalid1}, 0);
    end

`ifdef RAM_ARB_STALL_COUNT_EN
    check("st_rst0", stall0, 0);
    check("st_rst1", stall1, 0);
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    for (int k = 0; k < 4; k++) step();
    check("st_cnt0", stall0, 2);
    check("st_cnt1", stall1, 2);
    stat_clr = 1;
    step();
    stat_clr = 0;
    check("st_clr0", stall0, 0);
    check("st_clr1", stall1, 0);
    idle_inputs();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one single_port_ram (32x8 by default) between two independent requesters, e.g. two memset-style FSMs.
- Accepts one command per cycle, drives the registered RAM port, and returns read data with a per-requester valid strobe.
- Sits between the requester FSMs and the RAM instance. It replaces direct wiring of one FSM to the memory controller.

Parameters:
ADDR_WIDTH, 5, RAM address width (depth 2**ADDR_WIDTH)
DATA_WIDTH, 8, RAM data width

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 command request
we0  input  1  requester 0 write (1) / read (0)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 command accepted (1-cycle pulse)
rvalid0  output  1  requester 0 read data valid on rdata
req1, we1, addr1, wdata1, gnt1, rvalid1  same as above, for requester 1
rdata  output  DATA_WIDTH  read data, shared; qualify with rvalid0/rvalid1
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_we  output  1  to RAM we
ram_data  output  DATA_WIDTH  to RAM data
ram_out  input  DATA_WIDTH  from RAM out
busy  output  1  high when a command is issued this cycle or a read is in flight

Behaviour:
- Reset (async, immediate): gnt0=gnt1=0, rvalid0=rvalid1=0, ram_we=0, ram_addr=0, ram_data=0, last-winner register=1 (requester 0 wins the first tie), busy=0.
- Reset mid-operation discards any pending read. No rvalid follows reset release.
- Eligibility at each posedge: reqN=1 and gntN=0 in the current cycle. A just-granted requester is masked for one cycle, so each requester gets at most one grant per 2 cycles. The combined rate is 1 grant/cycle when both requesters alternate.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible: the requester that is not the last winner wins.
  - Last winner updates only on a grant.
- Issue, at the same edge as the grant:
  - gntN<=1.
  - ram_addr<=addrN, ram_data<=wdataN, ram_we<=weN. All RAM outputs are registered.
  - No winner: gnt*<=0, ram_we<=0; ram_addr and ram_data hold their values.
- Requester contract: hold reqN/weN/addrN/wdataN stable until gntN=1 is seen. In the cycle gntN=1, the requester may present the next command or drop req. It is not sampled for arbitration in that cycle.
- Read latency:
  - Grant edge E: gnt=1 during cycle E.
  - The RAM captures at edge E+1.
  - ram_out is valid in cycle E+1. The arbiter registers it into rdata at edge E+2, with rvalidN=1 for that one cycle.
  - Total: rvalid arrives 2 cycles after gnt.
- Read tag pipeline: 2-stage shift {valid, id}, so back-to-back reads from alternating requesters return in order with the correct rvalidN.
- Writes produce no rvalid. A read that is 1 cycle after a write to the same address returns the new data (the RAM is write-first).
- rdata holds its last value when no rvalid is asserted.
- busy = ram_we | issued-read-stage-1 | read-stage-2 (registered).
- Addresses wrap naturally at 2**ADDR_WIDTH. No range checking.

Optional Feature:
- Macro RAM_ARB_STALL_COUNT_EN.
- Defined:
  - Adds output ports stall0 and stall1, each 16 bits.
  - stallN increments each cycle reqN=1 and gntN stays 0 in the next cycle (lost arbitration or masked). The count saturates at 16'hFFFF.
  - Both counters clear on reset. They also clear synchronously on the new input stat_clr (1 bit), which has priority over increment.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, req0=1, we0=1, addr0=5, wdata0=8'hA5 -> gnt0 high 1 cycle after the edge. ram_we=1, ram_addr=5, ram_data=8'hA5 during that cycle. No rvalid.
- After the above, req1=1, we1=0, addr1=5 -> gnt1 pulse. Two cycles later rvalid1=1, rdata=8'hA5, rvalid0=0.
- req0 and req1 both held high with reads from addr 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1, with requester 0 first. rvalids alternate with the correct data.
- Single requester holding req0 continuously -> gnt0 pattern 1,0,1,0. Never two consecutive grants.
- Read granted, then reset asserted in the next cycle -> all outputs 0 immediately. No rvalid after reset release.
- With RAM_ARB_STALL_COUNT_EN defined, both requesting for 4 cycles -> each stall counter increments on cycles it is not granted. Pulse stat_clr -> both read 0 next cycle.
